// File: rtl/fetch_prefetch_unit_pkg.sv
// rtl/fetch_prefetch_unit_pkg.sv - shared widths, queue entry type and NOP constant for the fetch front end
package fetch_prefetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - ROM request/response and decode-side signals of the fetch unit
interface fetch_prefetch_unit_if;
  import fetch_prefetch_unit_pkg::*;

  logic [ADDR_W-1:0]  rom_address;
  logic               rom_req;
  logic [INSTR_W-1:0] rom_q;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [ADDR_W-1:0]  pc_out;
  logic [INSTR_W-1:0] instruction_out;

  modport master (
    output rom_address, rom_req, out_valid, pc_out, instruction_out,
    input  rom_q, stall, redirect, redirect_pc
  );

  modport slave (
    input  rom_address, rom_req, out_valid, pc_out, instruction_out,
    output rom_q, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// rtl/fetch_prefetch_unit_fifo.sv - circular prefetch queue of {pc, instr} with flush and occupancy count
module fetch_prefetch_unit_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, instr: INSTR_NOP};
      end
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - fetch PC, credit-based ROM issue and prefetch queue feeding decode
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_unit_if.master  bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              empty;
  logic [CW:0]       used;
  logic [CW:0]       limit;
  fetch_entry_t      head;
  fetch_entry_t      rsp;

  // A redirect flushes the queue, so neither the head nor the returning word survives it.
  assign pop  = !empty && !bus.stall && !bus.redirect;
  assign push = inflight && !bus.redirect;
  assign rsp  = '{pc: inflight_pc, instr: bus.rom_q};

  // Issue only if every queued and in-flight word still has a slot after this cycle's pop.
  assign used  = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  assign limit = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
  assign issue = reset && !bus.redirect && (used < limit);

  assign bus.rom_address     = fetch_pc;
  assign bus.rom_req         = issue;
  assign bus.out_valid       = !empty;
  assign bus.pc_out          = head.pc;
  assign bus.instruction_out = head.instr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
    end
  end

  fetch_prefetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (rsp),
    .rdata (head),
    .empty (empty),
    .count (occupancy)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed vector table plus a stall-heavy stream check for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic        cd;
    logic        ereq;
    logic [15:0] eaddr;
    logic [2:0]  eocc;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] occupancy;
  int         total;
  int         passed;
  vec_t       vecs[$];

  fetch_prefetch_unit_if bus();

  fetch_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: mem[i] = A000 + i, one cycle read latency.
  always @(posedge clk) begin
    bus.rom_q <= 16'hA000 + bus.rom_address;
  end

  function automatic void chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end else begin
      passed++;
    end
  endfunction

  function automatic void add(input logic rst, input logic st, input logic rd, input logic [15:0] rpc,
                              input logic ev, input logic [15:0] epc, input logic cd,
                              input logic ereq, input logic [15:0] eaddr, input logic [2:0] eocc);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.cd = cd;
    v.ereq = ereq; v.eaddr = eaddr; v.eocc = eocc;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        stall_now;

    total  = 0;
    passed = 0;
    reset           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;

    //  rst st rd rpc       ev epc      cd req addr     occ
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 3'd0); // held in reset
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 3'd0); // c0 release
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0001, 3'd0);
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'h0002, 3'd1); // first instr at cycle 2
    add(1, 0, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h0003, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0004, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0003, 1, 1, 16'h0005, 3'd1);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0006, 3'd1); // stall x6
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0007, 3'd2);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'h0008, 3'd3);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'h0008, 3'd4);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'h0008, 3'd4);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'h0008, 3'd4);
    add(1, 0, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0008, 3'd4); // release
    add(1, 0, 0, 16'h0000, 1, 16'h0005, 1, 1, 16'h0009, 3'd3);
    add(1, 0, 0, 16'h0000, 1, 16'h0006, 1, 1, 16'h000A, 3'd3);
    add(1, 0, 0, 16'h0000, 1, 16'h0007, 1, 1, 16'h000B, 3'd3);
    add(1, 0, 0, 16'h0000, 1, 16'h0008, 1, 1, 16'h000C, 3'd3);
    add(1, 0, 0, 16'h0000, 1, 16'h0009, 1, 1, 16'h000D, 3'd3);
    add(1, 0, 1, 16'h0040, 1, 16'h000A, 1, 0, 16'h000E, 3'd3); // redirect with 3 queued
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0040, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0041, 3'd0);
    add(1, 0, 0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0042, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0041, 1, 1, 16'h0043, 3'd1);
    add(1, 1, 1, 16'h0080, 1, 16'h0042, 1, 0, 16'h0044, 3'd1); // redirect + stall
    add(1, 0, 1, 16'h0010, 0, 16'h0000, 0, 0, 16'h0080, 3'd0); // back-to-back redirects
    add(1, 0, 1, 16'h0020, 0, 16'h0000, 0, 0, 16'h0010, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0020, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0021, 3'd0);
    add(1, 0, 0, 16'h0000, 1, 16'h0020, 1, 1, 16'h0022, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0021, 1, 1, 16'h0023, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0022, 1, 1, 16'h0024, 3'd1);
    add(1, 0, 1, 16'hFFFE, 1, 16'h0023, 1, 0, 16'h0025, 3'd1); // redirect near wrap
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'hFFFE, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'hFFFF, 3'd0);
    add(1, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 1, 16'h0000, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 1, 16'h0001, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'h0002, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h0003, 3'd1);
    add(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0004, 3'd1); // fill the queue
    add(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0005, 3'd2);
    add(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0006, 3'd3);
    add(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0006, 3'd4);
    add(0, 1, 1, 16'h0055, 1, 16'h0002, 1, 0, 16'h0006, 3'd4); // reset beats full+redirect
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 3'd0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0001, 3'd0);
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'h0002, 3'd1);
    add(1, 0, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h0003, 3'd1);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset           = vecs[i].rst;
      bus.stall       = vecs[i].st;
      bus.redirect    = vecs[i].rd;
      bus.redirect_pc = vecs[i].rpc;
      @(negedge clk);
      chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].ev));
      if (vecs[i].cd) begin
        exp_instr = vecs[i].ev ? 16'hA000 + vecs[i].epc : 16'h0000;
        chk("pc_out", i, 32'(bus.pc_out), 32'(vecs[i].epc));
        chk("instruction_out", i, 32'(bus.instruction_out), 32'(exp_instr));
      end
      chk("rom_req", i, 32'(bus.rom_req), 32'(vecs[i].ereq));
      chk("rom_address", i, 32'(bus.rom_address), 32'(vecs[i].eaddr));
      chk("occupancy", i, 32'(occupancy), 32'(vecs[i].eocc));
      @(posedge clk);
      #1;
    end

    // Random stalls: the stream must continue from pc 2 with no gap, duplicate or skip.
    exp_pc       = 16'h0002;
    bus.redirect = 1'b0;
    reset        = 1'b1;
    for (int k = 0; k < 80; k++) begin
      stall_now = ($urandom_range(0, 2) == 0);
      bus.stall = stall_now;
      @(negedge clk);
      if (bus.out_valid) begin
        chk("stream_pc", k, 32'(bus.pc_out), 32'(exp_pc));
        exp_instr = 16'hA000 + exp_pc;
        chk("stream_instr", k, 32'(bus.instruction_out), 32'(exp_instr));
        if (!stall_now) exp_pc = exp_pc + 16'h0001;
      end
      chk("occ_bound", k, 32'(occupancy <= 3'd4), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("stream_progress", 0, 32'(exp_pc >= 16'd22), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
